led_blink_gen: RTL and testbench

- Timebase generator for the baseboard LED mode decoder. It produces the blink waveforms that decoder consumes: CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS and CLK_07S.
- It divides SYSCLK down to a 25 ms tick, then derives every pattern from two phase counters, so all LEDs on the board blink in lock-step.
- A synchronous phase-clear input lets firmware restart every pattern at a known point.

---
 rtl/led_blink_gen.sv | 123 ++++++++++++
 tb/tb_led_blink_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_blink_gen.sv
// LED blink timebase. SYSCLK is divided down to a 25 ms tick. Two phase
// counters advance on that tick: a 160-tick (4 s) frame and a 56-tick (1.4 s)
// frame. Every blink waveform is decoded from these counters, so all LEDs stay
// in lock-step. SYNC_CLR restarts every pattern at phase 0.
module led_blink_gen #(
    parameter int TICK_CYCLES = 625000
) (
    input  logic SYSCLK,
    input  logic RESET_N,
    input  logic SYNC_CLR,
    output logic TICK_25MS,
    output logic CLK_1HZ,
    output logic CLK_2HZ,
    output logic CLK_4HZ,
    output logic CLK_4HZ_500MS,
    output logic CLK_4HZ_3500MS,
    output logic CLK_07S
);

    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    // Prescaler and phase counters. m10/m20/m40 track ph modulo 10/20/40;
    // because 160 is a multiple of 40 they wrap exactly in step with ph.
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       ph_q, ph_d;
    logic [5:0]       p7_q, p7_d;
    logic [3:0]       m10_q, m10_d;
    logic [4:0]       m20_q, m20_d;
    logic [5:0]       m40_q, m40_d;

    // Registered outputs.
    logic tick_q, tick_d;
    logic clk_1hz_q, clk_1hz_d;
    logic clk_2hz_q, clk_2hz_d;
    logic clk_4hz_q, clk_4hz_d;
    logic clk_4hz_500ms_q, clk_4hz_500ms_d;
    logic clk_4hz_3500ms_q, clk_4hz_3500ms_d;
    logic clk_07s_q, clk_07s_d;

    logic tick;

    // Next-state: prescaler, tick-gated phase counters, phase clear, decode.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        ph_d  = ph_q;
        p7_d  = p7_q;
        m10_d = m10_q;
        m20_d = m20_q;
        m40_d = m40_q;

        if (tick) begin
            ph_d  = (ph_q  == 8'd159) ? 8'd0 : ph_q  + 8'd1;
            p7_d  = (p7_q  == 6'd55)  ? 6'd0 : p7_q  + 6'd1;
            m10_d = (m10_q == 4'd9)   ? 4'd0 : m10_q + 4'd1;
            m20_d = (m20_q == 5'd19)  ? 5'd0 : m20_q + 5'd1;
            m40_d = (m40_q == 6'd39)  ? 6'd0 : m40_q + 6'd1;
        end

        // Phase clear wins over a coincident tick; that tick is dropped.
        if (SYNC_CLR) begin
            pre_d = '0;
            ph_d  = 8'd0;
            p7_d  = 6'd0;
            m10_d = 4'd0;
            m20_d = 5'd0;
            m40_d = 6'd0;
        end

        tick_d = tick & ~SYNC_CLR;

        // Decode from the updated counters so outputs move with the counters.
        clk_4hz_d        = (m10_d < 4'd5);
        clk_2hz_d        = (m20_d < 5'd10);
        clk_1hz_d        = (m40_d < 6'd20);
        clk_4hz_500ms_d  = (m40_d < 6'd20) & clk_4hz_d;
        clk_4hz_3500ms_d = (ph_d < 8'd20) & clk_4hz_d;
        clk_07s_d        = (p7_d < 6'd28);
    end

    // State registers; reset puts everything at phase 0 with outputs high.
    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            pre_q            <= '0;
            ph_q             <= 8'd0;
            p7_q             <= 6'd0;
            m10_q            <= 4'd0;
            m20_q            <= 5'd0;
            m40_q            <= 6'd0;
            tick_q           <= 1'b0;
            clk_1hz_q        <= 1'b1;
            clk_2hz_q        <= 1'b1;
            clk_4hz_q        <= 1'b1;
            clk_4hz_500ms_q  <= 1'b1;
            clk_4hz_3500ms_q <= 1'b1;
            clk_07s_q        <= 1'b1;
        end else begin
            pre_q            <= pre_d;
            ph_q             <= ph_d;
            p7_q             <= p7_d;
            m10_q            <= m10_d;
            m20_q            <= m20_d;
            m40_q            <= m40_d;
            tick_q           <= tick_d;
            clk_1hz_q        <= clk_1hz_d;
            clk_2hz_q        <= clk_2hz_d;
            clk_4hz_q        <= clk_4hz_d;
            clk_4hz_500ms_q  <= clk_4hz_500ms_d;
            clk_4hz_3500ms_q <= clk_4hz_3500ms_d;
            clk_07s_q        <= clk_07s_d;
        end
    end

    assign TICK_25MS      = tick_q;
    assign CLK_1HZ        = clk_1hz_q;
    assign CLK_2HZ        = clk_2hz_q;
    assign CLK_4HZ        = clk_4hz_q;
    assign CLK_4HZ_500MS  = clk_4hz_500ms_q;
    assign CLK_4HZ_3500MS = clk_4hz_3500ms_q;
    assign CLK_07S        = clk_07s_q;

endmodule

// File: tb/tb_led_blink_gen.sv
// Bench for led_blink_gen with a 4-cycle tick. Output vector order:
// {CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S}.
`timescale 1ns/1ps
module tb_led_blink_gen;

    localparam int TC = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sync_clr;
    logic tick_o, c1, c2, c4, c4b, c4l, c07;
    logic [5:0] outs;

    assign outs = {c1, c2, c4, c4b, c4l, c07};

    always #5 clk = ~clk;

    led_blink_gen #(.TICK_CYCLES(TC)) dut (
        .SYSCLK         (clk),
        .RESET_N        (rst_n),
        .SYNC_CLR       (sync_clr),
        .TICK_25MS      (tick_o),
        .CLK_1HZ        (c1),
        .CLK_2HZ        (c2),
        .CLK_4HZ        (c4),
        .CLK_4HZ_500MS  (c4b),
        .CLK_4HZ_3500MS (c4l),
        .CLK_07S        (c07)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock edge, then settle away from the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst_n;
        logic       clr;
        int         n;
        bit         every;
        logic       exp_tick;
        logic [5:0] exp_outs;
    } vec_t;

    vec_t vecs [13];

    logic [5:0] hist [0:640];
    logic       tick_hist [0:640];

    int hi_exp [6];
    int lo_exp [6];
    int pulse_exp [6];

    initial begin
        int last;
        int pulses;
        int len;
        int nticks;
        int last_tick;
        int hi_cnt;

        rst_n = 1'b0;
        sync_clr = 1'b0;

        // k = edges since reset release; ph = k/4, p7 = k/4 mod 56.
        vecs[0]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 6'b111111}; // in reset
        vecs[1]  = '{1'b1, 1'b0,  3, 1'b1, 1'b0, 6'b111111}; // k=1..3
        vecs[2]  = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 6'b111111}; // k=4 first tick
        vecs[3]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 6'b111111}; // k=5
        vecs[4]  = '{1'b1, 1'b0, 15, 1'b0, 1'b1, 6'b110001}; // k=20 ph=5
        vecs[5]  = '{1'b1, 1'b0, 20, 1'b0, 1'b1, 6'b101111}; // k=40 ph=10
        vecs[6]  = '{1'b1, 1'b0, 40, 1'b0, 1'b1, 6'b011001}; // k=80 ph=20
        vecs[7]  = '{1'b1, 1'b0, 32, 1'b0, 1'b1, 6'b010000}; // k=112 ph=28 p7=28
        vecs[8]  = '{1'b1, 1'b0,  2, 1'b0, 1'b0, 6'b010000}; // k=114
        vecs[9]  = '{1'b0, 1'b1,  2, 1'b1, 1'b0, 6'b111111}; // reset + clear
        vecs[10] = '{1'b1, 1'b1, 10, 1'b1, 1'b0, 6'b111111}; // clear held
        vecs[11] = '{1'b1, 1'b0,  3, 1'b1, 1'b0, 6'b111111}; // released
        vecs[12] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 6'b111111}; // tick 4 after

        for (int i = 0; i < 13; i++) begin
            rst_n = vecs[i].rst_n;
            sync_clr = vecs[i].clr;
            for (int c = 0; c < vecs[i].n; c++) begin
                step();
                if (vecs[i].every || c == vecs[i].n - 1) begin
                    check($sformatf("vec%0d_c%0d_tick", i, c), 32'(tick_o), 32'(vecs[i].exp_tick));
                    check($sformatf("vec%0d_c%0d_outs", i, c), 32'(outs), 32'(vecs[i].exp_outs));
                end
            end
            $display("vec %0d rst_n=%0b clr=%0b n=%0d tick=%0b outs=%06b", i,
                     vecs[i].rst_n, vecs[i].clr, vecs[i].n, tick_o, outs);
        end

        // Full 4 s frame from a clear: record 641 samples (edge 0 = clear).
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        hist[0] = outs;
        tick_hist[0] = tick_o;
        for (int j = 1; j <= 640; j++) begin
            step();
            hist[j] = outs;
            tick_hist[j] = tick_o;
        end
        check("frame_start_outs", 32'(hist[0]), 32'h3f);
        check("frame_start_tick", 32'(tick_hist[0]), 32'h0);

        // Bit index: 5=1HZ 4=2HZ 3=4HZ 2=500MS 1=3500MS 0=07S; -1 = unchecked.
        hi_exp[5] = 80;  lo_exp[5] = 80;  pulse_exp[5] = 4;
        hi_exp[4] = 40;  lo_exp[4] = 40;  pulse_exp[4] = 8;
        hi_exp[3] = 20;  lo_exp[3] = 20;  pulse_exp[3] = 16;
        hi_exp[2] = 20;  lo_exp[2] = -1;  pulse_exp[2] = 8;
        hi_exp[1] = 20;  lo_exp[1] = -1;  pulse_exp[1] = 2;
        hi_exp[0] = 112; lo_exp[0] = 112; pulse_exp[0] = 3;

        for (int b = 0; b < 6; b++) begin
            last = 0;
            pulses = hist[0][b] ? 1 : 0;
            for (int j = 1; j <= 640; j++) begin
                if (hist[j][b] !== hist[j-1][b]) begin
                    len = j - last;
                    if (hist[j-1][b] === 1'b1)
                        check($sformatf("bit%0d_high_run_end%0d", b, j), 32'(len), 32'(hi_exp[b]));
                    else if (lo_exp[b] >= 0)
                        check($sformatf("bit%0d_low_run_end%0d", b, j), 32'(len), 32'(lo_exp[b]));
                    if (hist[j][b] === 1'b1 && j < 640)
                        pulses++;
                    last = j;
                end
            end
            check($sformatf("bit%0d_pulses", b), 32'(pulses), 32'(pulse_exp[b]));
            $display("frame bit %0d pulses=%0d", b, pulses);
        end

        nticks = 0;
        last_tick = 0;
        for (int j = 1; j <= 640; j++) begin
            if (tick_hist[j] === 1'b1) begin
                check($sformatf("tick_spacing_at%0d", j), 32'(j - last_tick), 32'(TC));
                nticks++;
                last_tick = j;
            end
        end
        check("tick_count", 32'(nticks), 32'd160);
        $display("frame ticks=%0d", nticks);

        hi_cnt = 0;
        for (int j = 80; j < 640; j++)
            if (hist[j][1] !== 1'b0) hi_cnt++;
        check("burst3500_quiet_after80", 32'(hi_cnt), 32'd0);

        // ph 159 -> 0 wrap: the five ph-derived outputs all low, then all high.
        check("wrap_ph159_first", 32'(hist[636][5:1]), 32'h00);
        check("wrap_ph159_last", 32'(hist[639][5:1]), 32'h00);
        check("wrap_ph0", 32'(hist[640][5:1]), 32'h1f);
        $display("wrap before=%05b after=%05b", hist[639][5:1], hist[640][5:1]);

        // Clear coinciding with the tick cycle at ph=73 (pre=3).
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        for (int j = 0; j < 295; j++) step();
        check("ph73_outs", 32'(outs), 32'(6'b001001));
        check("ph73_tick", 32'(tick_o), 32'h0);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("clr_on_tick_outs", 32'(outs), 32'h3f);
        check("clr_on_tick_tick", 32'(tick_o), 32'h0);
        $display("sync_clr at ph73 tick outs=%06b tick=%0b", outs, tick_o);
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("post_clr_tick_c%0d", c), 32'(tick_o), 32'(c == 4));
        end
        check("post_clr_ph1_outs", 32'(outs), 32'h3f);
        for (int c = 5; c <= 20; c++) step();
        check("post_clr_ph5_outs", 32'(outs), 32'(6'b110001));
        check("post_clr_ph5_tick", 32'(tick_o), 32'h1);
        $display("restart ph5 outs=%06b tick=%0b", outs, tick_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
